// File: rtl/codec_init_pkg.sv
// Shared FSM states, register table and constants for the codec power-up sequencer.
package codec_init_pkg;

  localparam int         LUT_SIZE = 11;
  localparam logic [7:0] GO_BYTE  = 8'h01;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WR0,
    WR1,
    WR2,
    WR3,
    WAIT,
    NEXT,
    DONE
  } state_t;

  // Each word is {reg[6:0], data[8:0]} in codec register-write format.
  localparam logic [15:0] ROM_TABLE [LUT_SIZE] = '{
    16'h0000, 16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h08F8,
    16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201
  };

endpackage

// File: rtl/codec_init_rom.sv
// Combinational lookup of the codec register table; out-of-range indices read as zero.
module codec_init_rom
  import codec_init_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < LUT_SIZE; i++) begin
      if (idx_i == 4'(i)) word_o = ROM_TABLE[i];
    end
  end

endmodule

// File: rtl/codec_init_seq.sv
// Codec init sequencer: each ROM word goes out as four Avalon byte writes, first write 2 cycles after Start.
// No backpressure; each entry waits for Iic_Done or timeout. CODEC_INIT_RETRY_EN enables per-entry retries.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         TIMEOUT_CYCLES = 400000,
  parameter bit         AUTO_START     = 1'b1,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       Clk_In,
  input  logic       Reset,
  input  logic       Start,
  output logic [1:0] Avalon_Address,
  output logic [7:0] Avalon_Writedata,
  output logic       Avalon_Write,
  input  logic       Iic_Done,
  input  logic       Iic_Nack,
  output logic       Init_Busy,
  output logic       Init_Done,
  output logic       Init_Error,
  output logic [3:0] Err_Index
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [23:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       eidx_q, eidx_d;
  logic             auto_q;
  logic [15:0]      rom_word;
  logic             fail;
  logic             final_fail;

`ifdef CODEC_INIT_RETRY_EN
  localparam int          RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;
`else
  // Retry limit only matters in the retry build.
  localparam int unused_max_retry = MAX_RETRY;
`endif

  codec_init_rom u_rom (
    .idx_i  (idx_q),
    .word_o (rom_word)
  );

  always_ff @(posedge Clk_In or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
      auto_q  <= AUTO_START;
`ifdef CODEC_INIT_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
      auto_q  <= 1'b0;
`ifdef CODEC_INIT_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    eidx_d     = eidx_q;
    fail       = 1'b0;
    final_fail = 1'b0;
`ifdef CODEC_INIT_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start || auto_q) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          eidx_d  = '0;
          idx_d   = '0;
          state_d = LOAD;
`ifdef CODEC_INIT_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      LOAD: begin
        word_d  = {DEV_ADDR, rom_word};
        state_d = WR0;
      end
      WR0: state_d = WR1;
      WR1: state_d = WR2;
      WR2: state_d = WR3;
      WR3: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the same cycle as the timeout wins.
        if (Iic_Done) begin
          if (Iic_Nack) fail = 1'b1;
          else          state_d = NEXT;
        end else if (cnt_q == CNT_LAST) begin
          fail = 1'b1;
        end
        if (fail) begin
          final_fail = 1'b1;
          state_d    = NEXT;
`ifdef CODEC_INIT_RETRY_EN
          if (retry_q < RETRY_MAX) begin
            retry_d    = retry_q + 1'b1;
            final_fail = 1'b0;
            state_d    = LOAD;
          end
`endif
          if (final_fail && !err_q) begin
            err_d  = 1'b1;
            eidx_d = idx_q;
          end
        end
      end
      NEXT: begin
`ifdef CODEC_INIT_RETRY_EN
        retry_d = '0;
`endif
        if (idx_q < 4'(LUT_SIZE - 1)) begin
          idx_d   = idx_q + 4'd1;
          state_d = LOAD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Avalon_Write     = 1'b0;
    Avalon_Address   = 2'd0;
    Avalon_Writedata = 8'd0;
    case (state_q)
      WR0: begin Avalon_Write = 1'b1; Avalon_Address = 2'd0; Avalon_Writedata = word_q[7:0];   end
      WR1: begin Avalon_Write = 1'b1; Avalon_Address = 2'd1; Avalon_Writedata = word_q[15:8];  end
      WR2: begin Avalon_Write = 1'b1; Avalon_Address = 2'd2; Avalon_Writedata = word_q[23:16]; end
      WR3: begin Avalon_Write = 1'b1; Avalon_Address = 2'd3; Avalon_Writedata = GO_BYTE;       end
      default: ;
    endcase
  end

  assign Init_Busy  = (state_q != IDLE);
  assign Init_Done  = done_q;
  assign Init_Error = err_q;
  assign Err_Index  = eidx_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: table rows, random fault patterns, mid-flight reset and timeout instance.
module tb_codec_init_seq;

  localparam int TB_MAX_RETRY = 3;
  localparam int N_ENT        = 11;
`ifdef CODEC_INIT_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n, start, done_in, nack_in;
  logic [1:0] addr;
  logic [7:0] wdat;
  logic       wr, busy, idone, ierr;
  logic [3:0] eidx;

  logic       start_to, done_to_in, nack_to_in;
  logic [1:0] addr_to;
  logic [7:0] wdat_to;
  logic       wr_to, busy_to, idone_to, ierr_to;
  logic [3:0] eidx_to;

  codec_init_seq #(.DEV_ADDR(8'h34), .TIMEOUT_CYCLES(400000), .AUTO_START(1'b1), .MAX_RETRY(TB_MAX_RETRY)) dut (
    .Clk_In(clk), .Reset(rst_n), .Start(start),
    .Avalon_Address(addr), .Avalon_Writedata(wdat), .Avalon_Write(wr),
    .Iic_Done(done_in), .Iic_Nack(nack_in),
    .Init_Busy(busy), .Init_Done(idone), .Init_Error(ierr), .Err_Index(eidx)
  );

  codec_init_seq #(.DEV_ADDR(8'h34), .TIMEOUT_CYCLES(50), .AUTO_START(1'b0), .MAX_RETRY(TB_MAX_RETRY)) dut_to (
    .Clk_In(clk), .Reset(rst_n), .Start(start_to),
    .Avalon_Address(addr_to), .Avalon_Writedata(wdat_to), .Avalon_Write(wr_to),
    .Iic_Done(done_to_in), .Iic_Nack(nack_to_in),
    .Init_Busy(busy_to), .Init_Done(idone_to), .Init_Error(ierr_to), .Err_Index(eidx_to)
  );

  int n_chk = 0, n_err = 0, cyc = 0;
  logic [15:0] ref_rom [N_ENT];
  logic [9:0]  got_q[$], exp_q[$];
  bit          plan_q[$];
  int          first_wr_cyc, idle_bad = 0;
  bit          go_seen;
  int          to_wr = 0, to_go_n = 0, to_last_go = -1, to_gap_bad = 0;

  typedef struct {
    bit          auto_go;
    logic [10:0] mask;
    int          times;
    int          delay;
    bit          poke;
    bit          spur;
    int          x_err;
    int          x_eidx;
    int          x_wr;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 50 WAIT cycles then NEXT+LOAD (or LOAD only on a retry) before the next WR0.
  function automatic int exp_gap(input int go_idx);
    if (RETRY && (go_idx % (TB_MAX_RETRY + 1)) < TB_MAX_RETRY) return 52;
    return 53;
  endfunction

  task automatic step();
    int gap;
    @(negedge clk);
    cyc++;
    go_seen = 1'b0;
    if (wr) begin
      if (got_q.size() == 0) first_wr_cyc = cyc;
      got_q.push_back({addr, wdat});
      if (addr == 2'd3) go_seen = 1'b1;
    end else if (addr != 2'd0 || wdat != 8'd0) begin
      idle_bad++;
    end
    if (wr_to) begin
      to_wr++;
      if (addr_to == 2'd0 && to_last_go >= 0) begin
        gap = cyc - to_last_go;
        if (gap != exp_gap(to_go_n - 1)) to_gap_bad++;
        to_last_go = -1;
      end
      if (addr_to == 2'd3) begin
        to_last_go = cyc;
        to_go_n++;
      end
    end
  endtask

  // Reference: every attempt is 4 writes; a failing attempt retries (retry build) up to
  // TB_MAX_RETRY extra times, and the first entry that fails finally is recorded.
  function automatic void model(input logic [10:0] mask, input int times, output int e_err, output int e_idx);
    int att;
    bit fail, settled;
    logic [23:0] w;
    exp_q.delete();
    plan_q.delete();
    e_err = 0;
    e_idx = 0;
    for (int i = 0; i < N_ENT; i++) begin
      att = 0;
      settled = 1'b0;
      w = {8'h34, ref_rom[i]};
      while (!settled) begin
        exp_q.push_back({2'd0, w[7:0]});
        exp_q.push_back({2'd1, w[15:8]});
        exp_q.push_back({2'd2, w[23:16]});
        exp_q.push_back({2'd3, 8'h01});
        fail = mask[i] && (att < times);
        plan_q.push_back(fail);
        if (!fail) settled = 1'b1;
        else if (RETRY && att < TB_MAX_RETRY) att++;
        else begin
          if (e_err == 0) begin e_err = 1; e_idx = i; end
          settled = 1'b1;
        end
      end
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // I2C slave stand-in: answers each go write after a delay with the planned NACK flag.
  task automatic drive(input int delay_fix, input int stop_at, input bit poke, input bit spur, output bit tmo);
    int pend, k, guard;
    bit cur, started, fin, poked, spurred;
    pend = 0; k = 0; guard = 0;
    cur = 0; started = 0; fin = 0; poked = 0; spurred = 0;
    tmo = 1'b0;
    while (!fin) begin
      step();
      start = 1'b0; done_in = 1'b0; nack_in = 1'b0;
      if (busy) started = 1'b1;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin done_in = 1'b1; nack_in = cur; end
      end
      if (go_seen) begin
        pend = (delay_fix > 0) ? delay_fix : int'($urandom_range(1, 40));
        cur  = (k < plan_q.size()) ? plan_q[k] : 1'b0;
        k++;
      end
      if (poke && !poked && got_q.size() == 10) begin start = 1'b1; poked = 1'b1; end
      if (spur && !spurred && got_q.size() == 5 && !done_in) begin
        done_in = 1'b1; nack_in = 1'b1; spurred = 1'b1;
      end
      if (started && !busy) fin = 1'b1;
      if (stop_at > 0 && got_q.size() >= stop_at) fin = 1'b1;
      guard++;
      if (guard > 20000) begin fin = 1'b1; tmo = 1'b1; end
    end
    start = 1'b0; done_in = 1'b0; nack_in = 1'b0;
  endtask

  task automatic row_checks(input string tag, input int x_err, input int x_eidx, input int x_wr, input int s_cyc, input bit tmo);
    check({tag, " timeout"}, tmo, 0);
    check({tag, " done"}, idone, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " error"}, ierr, x_err);
    check({tag, " err_index"}, eidx, x_eidx);
    check({tag, " write_count"}, got_q.size(), x_wr);
    check({tag, " stream_first_diff"}, first_diff(), -1);
    check({tag, " start_latency"}, first_wr_cyc - s_cyc, 2);
  endtask

  initial begin
    int s_cyc, e_err, e_idx, guard;
    bit tmo, started;
    logic [10:0] rmask;
    int rtimes;

    ref_rom[0] = 16'h0000; ref_rom[1] = 16'h001A; ref_rom[2]  = 16'h021A;
    ref_rom[3] = 16'h047B; ref_rom[4] = 16'h067B; ref_rom[5]  = 16'h08F8;
    ref_rom[6] = 16'h0A06; ref_rom[7] = 16'h0C00; ref_rom[8]  = 16'h0E01;
    ref_rom[9] = 16'h1002; ref_rom[10] = 16'h1201;

    tbl[0] = '{1'b1, 11'h000, 0,  100, 1'b0, 1'b0, 0, 0, 44};
    tbl[1] = '{1'b0, 11'h020, 99, 0,   1'b0, 1'b0, 1, 5, RETRY ? 56 : 44};
    tbl[2] = '{1'b0, 11'h020, 2,  100, 1'b0, 1'b0, RETRY ? 0 : 1, RETRY ? 0 : 5, RETRY ? 52 : 44};
    tbl[3] = '{1'b0, 11'h400, 1,  0,   1'b1, 1'b0, RETRY ? 0 : 1, RETRY ? 0 : 10, RETRY ? 48 : 44};
    tbl[4] = '{1'b0, 11'h001, 99, 0,   1'b0, 1'b1, 1, 0, RETRY ? 56 : 44};
    tbl[5] = '{1'b0, 11'h088, 99, 0,   1'b0, 1'b0, 1, 3, RETRY ? 68 : 44};
    tbl[6] = '{1'b0, 11'h000, 0,  0,   1'b1, 1'b1, 0, 0, 44};

    rst_n = 1'b0; start = 1'b0; done_in = 1'b0; nack_in = 1'b0;
    start_to = 1'b0; done_to_in = 1'b0; nack_to_in = 1'b0;
    repeat (3) step();
    check("reset write", wr, 0);
    check("reset address", addr, 0);
    check("reset writedata", wdat, 0);
    check("reset busy", busy, 0);
    check("reset done", idone, 0);
    check("reset error", ierr, 0);
    check("reset err_index", eidx, 0);
    check("reset busy_to", busy_to, 0);

    for (int r = 0; r < 7; r++) begin
      model(tbl[r].mask, tbl[r].times, e_err, e_idx);
      got_q.delete();
      s_cyc = cyc;
      if (tbl[r].auto_go) rst_n = 1'b1;
      else                start = 1'b1;
      drive(tbl[r].delay, 0, tbl[r].poke, tbl[r].spur, tmo);
      row_checks($sformatf("row%0d", r), tbl[r].x_err, tbl[r].x_eidx, tbl[r].x_wr, s_cyc, tmo);
      if (r == 0) begin
        check("first write 0", got_q.size() > 0 ? int'(got_q[0]) : -1, 'h000);
        check("first write 1", got_q.size() > 1 ? int'(got_q[1]) : -1, 'h100);
        check("first write 2", got_q.size() > 2 ? int'(got_q[2]) : -1, 'h234);
        check("first write 3", got_q.size() > 3 ? int'(got_q[3]) : -1, 'h301);
      end
    end

    for (int r = 0; r < 4; r++) begin
      rmask  = 11'($urandom_range(0, 2047) & $urandom_range(0, 2047));
      rtimes = int'($urandom_range(0, 4));
      model(rmask, rtimes, e_err, e_idx);
      got_q.delete();
      s_cyc = cyc;
      start = 1'b1;
      drive(0, 0, 1'b0, 1'b0, tmo);
      row_checks($sformatf("rand%0d", r), e_err, e_idx, exp_q.size(), s_cyc, tmo);
    end

    // Reset while entry 3 is in WR2, then the auto-start run must begin again at entry 0.
    got_q.delete();
    rst_n = 1'b0;
    step();
    model(11'h000, 0, e_err, e_idx);
    rst_n = 1'b1;
    drive(0, 15, 1'b0, 1'b0, tmo);
    check("midreset reached WR2", (got_q.size() == 15 && wr) ? int'(got_q[14]) : -1, 'h234);
    rst_n = 1'b0;
    #1;
    check("midreset write falls", wr, 0);
    check("midreset busy falls", busy, 0);
    repeat (3) step();
    check("midreset no writes in reset", got_q.size(), 15);
    got_q.delete();
    s_cyc = cyc;
    rst_n = 1'b1;
    drive(0, 0, 1'b0, 1'b0, tmo);
    row_checks("restart", 0, 0, 44, s_cyc, tmo);

    // Timeout instance: Iic_Done never returns.
    start_to = 1'b1;
    step();
    start_to = 1'b0;
    started = busy_to;
    guard = 0;
    while ((!started || busy_to) && guard < 20000) begin
      step();
      if (busy_to) started = 1'b1;
      guard++;
    end
    check("tmo finished in budget", guard < 20000, 1);
    check("tmo write_count", to_wr, RETRY ? 176 : 44);
    check("tmo go_count", to_go_n, RETRY ? 44 : 11);
    check("tmo wait_gaps_bad", to_gap_bad, 0);
    check("tmo done", idone_to, 1);
    check("tmo error", ierr_to, 1);
    check("tmo err_index", eidx_to, 0);

    check("idle bus zero", idle_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
